stopwatch_bcd4: RTL and testbench

Four-digit BCD stopwatch core (SS.cc, 00.00–99.99 s) running on the 1 kHz board clock. Debounces the start/stop and clear pushbuttons, runs a RUN/STOP state machine and a 10 ms prescaler, and presents four packed BCD digits plus a decimal-point mask. Sits directly upstream of the 4-digit 7-segment scan driver, which consumes `bcd` and `dp` unchanged.

---
 rtl/stopwatch_bcd4.sv | 147 ++++++++++++++
 tb/tb_stopwatch_bcd4.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd4.sv
// Four-digit BCD stopwatch (SS.cc) with debounced start/stop and clear buttons,
// a RUN/STOP/IDLE state machine and a centisecond prescaler.
module stopwatch_bcd4 #(
  parameter int TICK_DIV = 10,
  parameter int DEBOUNCE = 20
) (
  input  logic        clk_1k,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [15:0] bcd,
  output logic [3:0]  dp,
  output logic        running,
  output logic        ovf
);

  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t            state_reg;
  logic [TICK_W-1:0] presc_reg;
  logic              running_reg;
  logic              ovf_reg;
  logic [1:0]        btn_raw;
  logic [1:0]        press;
  logic [4:0]        carry;
  logic              tick;
  logic              clear_go;

  assign btn_raw = {btn_clr, btn_ss};

  // A button only becomes armed after it has been seen released for DEBOUNCE
  // cycles, so a button held through reset cannot trigger until re-pressed.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            meta_reg, sync_reg, level_reg, prev_reg, armed_reg;
      logic [DB_W-1:0] db_cnt_reg, arm_cnt_reg;

      always_ff @(posedge clk_1k) begin
        if (reset) begin
          meta_reg    <= 1'b0;
          sync_reg    <= 1'b0;
          level_reg   <= 1'b0;
          prev_reg    <= 1'b0;
          armed_reg   <= 1'b0;
          db_cnt_reg  <= '0;
          arm_cnt_reg <= '0;
        end else begin
          meta_reg <= btn_raw[gi];
          sync_reg <= meta_reg;
          prev_reg <= level_reg;
          if (sync_reg != level_reg) begin
            if (db_cnt_reg == DB_W'(DEBOUNCE - 1)) begin
              level_reg  <= sync_reg;
              db_cnt_reg <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            db_cnt_reg <= '0;
          end
          if (!armed_reg) begin
            if (sync_reg || level_reg)
              arm_cnt_reg <= '0;
            else if (arm_cnt_reg == DB_W'(DEBOUNCE - 1))
              armed_reg <= 1'b1;
            else
              arm_cnt_reg <= arm_cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = level_reg && !prev_reg && armed_reg;
    end
  endgenerate

  assign tick     = (state_reg == RUN) && (presc_reg == TICK_W'(TICK_DIV - 1));
  assign clear_go = (state_reg == STOP) && press[1];
  assign carry[0] = tick;

  // Ripple-carry decade chain; gi = 0 is cs_ones in bcd[3:0].
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      logic [3:0] digit_reg;

      always_ff @(posedge clk_1k) begin
        if (reset || clear_go)
          digit_reg <= 4'd0;
        else if (carry[gi])
          digit_reg <= (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      end

      assign carry[gi+1]       = carry[gi] && (digit_reg == 4'd9);
      assign bcd[gi*4 +: 4]    = digit_reg;
    end
  endgenerate

  always_ff @(posedge clk_1k) begin
    if (reset) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      running_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // clr wins over a coincident ss press here
          if (!press[1] && press[0]) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        RUN: begin
          presc_reg <= tick ? '0 : presc_reg + 1'b1;
          if (carry[4])
            ovf_reg <= 1'b1;
          if (press[0]) begin
            state_reg   <= STOP;
            running_reg <= 1'b0;
          end
        end
        STOP: begin
          if (press[1]) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            ovf_reg   <= 1'b0;
          end else if (press[0]) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  assign running = running_reg;
  assign ovf     = ovf_reg;
  assign dp      = 4'b0100;

endmodule

// File: tb/tb_stopwatch_bcd4.sv
// Directed self-checking bench for stopwatch_bcd4: a TICK_DIV=10 instance for
// button/state behaviour and a TICK_DIV=1 instance to reach the 99.99 wrap quickly.
module tb_stopwatch_bcd4;

  logic        clk_1k = 1'b0;
  logic        reset, btn_ss, btn_clr;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        running, ovf;

  logic        reset_f, ss_f, clr_f;
  logic [15:0] bcd_f;
  logic [3:0]  dp_f;
  logic        running_f, ovf_f;

  int checks = 0;
  int errors = 0;

  stopwatch_bcd4 #(.TICK_DIV(10), .DEBOUNCE(4)) dut (
    .clk_1k(clk_1k), .reset(reset), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .bcd(bcd), .dp(dp), .running(running), .ovf(ovf)
  );

  stopwatch_bcd4 #(.TICK_DIV(1), .DEBOUNCE(4)) dut_fast (
    .clk_1k(clk_1k), .reset(reset_f), .btn_ss(ss_f), .btn_clr(clr_f),
    .bcd(bcd_f), .dp(dp_f), .running(running_f), .ovf(ovf_f)
  );

  always #5 clk_1k = ~clk_1k;

  task automatic step(input int n);
    repeat (n) @(posedge clk_1k);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
    $display("check %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_running(input logic val, input int budget, input string tag);
    int n = 0;
    while (running !== val && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, {15'd0, running}, {15'd0, val});
  endtask

  initial begin
    reset = 1'b1; btn_ss = 1'b1; btn_clr = 1'b1;
    reset_f = 1'b1; ss_f = 1'b0; clr_f = 1'b0;

    // Reset with buttons held
    step(3);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_ovf", {15'd0, ovf}, 16'd0);
    chk("dp_const", {12'd0, dp}, 16'h0004);
    reset = 1'b0; btn_clr = 1'b0;
    step(20);
    chk("held_no_press", {15'd0, running}, 16'd0);
    btn_ss = 1'b0;
    step(20);
    chk("release_no_press", {15'd0, running}, 16'd0);

    // Start, run 250 cycles, stop
    btn_ss = 1'b1;
    wait_running(1'b1, 20, "start_run");
    btn_ss = 1'b0;
    step(250);
    btn_ss = 1'b1;
    wait_running(1'b0, 20, "stop_run");
    btn_ss = 1'b0;
    chk("stop_bcd", bcd, 16'h0025);
    step(100);
    chk("frozen_bcd", bcd, 16'h0025);
    chk("frozen_running", {15'd0, running}, 16'd0);

    // Resume continues partial interval (prescaler held at 7)
    btn_ss = 1'b1;
    wait_running(1'b1, 20, "resume_run");
    btn_ss = 1'b0;
    chk("resume_bcd0", bcd, 16'h0025);
    step(2);
    chk("resume_bcd2", bcd, 16'h0025);
    step(1);
    chk("resume_tick", bcd, 16'h0026);

    // Clear while running is ignored
    btn_clr = 1'b1;
    step(12);
    btn_clr = 1'b0;
    chk("clr_run_running", {15'd0, running}, 16'd1);
    chk("clr_run_bcd", bcd, 16'h0027);
    step(10);
    chk("clr_run_bcd2", bcd, 16'h0028);

    // Stop at 00.37 then clear
    step(85);
    btn_ss = 1'b1;
    wait_running(1'b0, 20, "stop37_run");
    btn_ss = 1'b0;
    chk("stop37_bcd", bcd, 16'h0037);
    step(10);
    btn_clr = 1'b1;
    step(8);
    btn_clr = 1'b0;
    chk("clear_bcd", bcd, 16'h0000);
    chk("clear_running", {15'd0, running}, 16'd0);
    step(12);

    // Debounce: short glitch rejected, bounce train gives one start
    btn_ss = 1'b1;
    step(3);
    btn_ss = 1'b0;
    step(15);
    chk("glitch_running", {15'd0, running}, 16'd0);
    repeat (3) begin
      btn_ss = 1'b1; step(2);
      btn_ss = 1'b0; step(2);
    end
    btn_ss = 1'b1;
    wait_running(1'b1, 30, "bounce_run");
    step(9);
    chk("idle_first_tick_pre", bcd, 16'h0000);
    step(1);
    chk("idle_first_tick", bcd, 16'h0001);
    step(20);
    chk("held_single_press", {15'd0, running}, 16'd1);
    chk("held_bcd", bcd, 16'h0003);
    btn_ss = 1'b0;
    step(10);
    chk("pre_sim_bcd", bcd, 16'h0004);

    // Simultaneous ss+clr: RUN -> STOP, then STOP -> IDLE
    btn_ss = 1'b1; btn_clr = 1'b1;
    wait_running(1'b0, 20, "sim_run_stop");
    chk("sim_run_bcd", bcd, 16'h0004);
    btn_ss = 1'b0; btn_clr = 1'b0;
    step(15);
    chk("sim_run_hold_bcd", bcd, 16'h0004);
    btn_ss = 1'b1; btn_clr = 1'b1;
    step(8);
    btn_ss = 1'b0; btn_clr = 1'b0;
    chk("sim_stop_bcd", bcd, 16'h0000);
    chk("sim_stop_running", {15'd0, running}, 16'd0);
    step(15);
    chk("sim_stop_idle", {15'd0, running}, 16'd0);

    // Wrap 99.99 -> 00.00 on the fast instance
    reset_f = 1'b0;
    step(10);
    ss_f = 1'b1;
    step(7);
    chk("fast_running", {15'd0, running_f}, 16'd1);
    ss_f = 1'b0;
    step(9990);
    chk("fast_9990", bcd_f, 16'h9990);
    step(9);
    chk("fast_9999", bcd_f, 16'h9999);
    chk("fast_ovf_pre", {15'd0, ovf_f}, 16'd0);
    step(1);
    chk("wrap_bcd", bcd_f, 16'h0000);
    chk("wrap_ovf", {15'd0, ovf_f}, 16'd1);
    chk("wrap_running", {15'd0, running_f}, 16'd1);
    step(5);
    ss_f = 1'b1;
    step(7);
    ss_f = 1'b0;
    chk("wrap_stop", {15'd0, running_f}, 16'd0);
    step(10);
    chk("ovf_sticky", {15'd0, ovf_f}, 16'd1);
    clr_f = 1'b1;
    step(8);
    clr_f = 1'b0;
    chk("ovf_cleared", {15'd0, ovf_f}, 16'd0);
    chk("wrap_clear_bcd", bcd_f, 16'h0000);
    chk("dp_fast", {12'd0, dp_f}, 16'h0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
